// File: rtl/sseg_scan_array.sv
// Multiplexed seven-segment driver with a shadow/active digit bank, PWM brightness and frame-aligned commits.
// Optional blink support is compiled in when SSEG_BLINK_EN is defined.
module sseg_scan_array #(
  parameter int SSEG_N       = 4,
  parameter int SSEG_BITS    = 2,
  parameter int PWM_BITS     = 2,
  parameter int PRESCALE     = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr,
  input  logic [SSEG_BITS-1:0] sel,
  input  logic [3:0]           val,
  input  logic                 en,
  input  logic                 sign,
  input  logic                 dp,
  input  logic                 blink,
  input  logic [PWM_BITS-1:0]  brightness,
  output logic [7:0]           sseg,
  output logic [SSEG_N-1:0]    oe,
  output logic                 done_tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [SSEG_BITS-1:0] LAST_DIGIT = SSEG_BITS'(SSEG_N - 1);

  typedef struct packed {
    logic [3:0] val;
    logic       en;
    logic       sign;
    logic       dp;
  } digit_t;

  logic [PS_W-1:0]      prescale;
  logic [PWM_BITS-1:0]  pwm;
  logic [PWM_BITS-1:0]  bright_q;
  logic [SSEG_BITS-1:0] digit;
  digit_t               shadow [SSEG_N];
  digit_t               active [SSEG_N];
  digit_t               cur;
  logic                 step_end;
  logic                 frame_end;
  logic                 wr_ok;
  logic                 hide;
  logic [6:0]           font;
  logic [7:0]           sseg_next;
  logic [SSEG_N-1:0]    oe_next;

  assign step_end  = (prescale == PS_LAST);
  assign frame_end = step_end && (pwm == '1) && (digit == LAST_DIGIT);
  // Widened compare so the range check stays meaningful when 2**SSEG_BITS == SSEG_N.
  assign wr_ok     = wr && ({1'b0, sel} < (SSEG_BITS + 1)'(SSEG_N));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      pwm      <= '0;
      digit    <= '0;
    end else begin
      prescale <= step_end ? '0 : prescale + 1'b1;
      if (step_end) begin
        pwm <= pwm + 1'b1;
        if (pwm == '1)
          digit <= (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
      end
    end
  end

  // Writes land in shadow; the visible bank only changes on the last clock of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SSEG_N; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      bright_q  <= '0;
      done_tick <= 1'b0;
    end else begin
      if (frame_end) begin
        for (int i = 0; i < SSEG_N; i++)
          active[i] <= shadow[i];
        bright_q <= brightness;
      end
      if (wr_ok)
        shadow[sel] <= {val, en, sign, dp};
      done_tick <= frame_end;
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0]   frame_cnt;
  logic              blink_on;
  logic [SSEG_N-1:0] shadow_blink;
  logic [SSEG_N-1:0] active_blink;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt    <= '0;
      blink_on     <= 1'b1;
      shadow_blink <= '0;
      active_blink <= '0;
    end else begin
      if (frame_end) begin
        active_blink <= shadow_blink;
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      if (wr_ok)
        shadow_blink[sel] <= blink;
    end
  end

  assign hide = !blink_on && |(active_blink & (SSEG_N'(1) << digit));
`else
  logic unused_blink;
  assign unused_blink = blink | (BLINK_FRAMES == 0);
  assign hide         = 1'b0;
`endif

  // Active-low font for segments g..a; the dp bit is added separately.
  always_comb begin
    cur       = active[digit];
    font      = 7'h7F;
    oe_next   = '0;
    sseg_next = 8'hFF;
    case (cur.val)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      4'hF: font = 7'h0E;
      default: font = 7'h7F;
    endcase
    if (cur.en && !hide) begin
      sseg_next = cur.sign ? {~cur.dp, 7'h3F} : {~cur.dp, font};
      // pwm step 0 is kept dark so the previous digit cannot ghost into this slot.
      if (pwm != '0 && pwm <= bright_q)
        oe_next = SSEG_N'(1) << digit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sseg <= 8'hFF;
      oe   <= '0;
    end else begin
      sseg <= sseg_next;
      oe   <= oe_next;
    end
  end

endmodule

// File: tb/tb_sseg_scan_array.sv
// Scoreboard bench for sseg_scan_array (3 digits, 2-bit PWM, 12-clock frame), default build without blink.
module tb_sseg_scan_array;

  localparam int N     = 3;
  localparam int FRAME = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr;
  logic [1:0] sel;
  logic [3:0] val;
  logic       en;
  logic       sign;
  logic       dp;
  logic       blink;
  logic [1:0] brightness;
  logic [7:0] sseg;
  logic [2:0] oe;
  logic       done_tick;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] val;
    logic       en;
    logic       sign;
    logic       dp;
  } digit_t;

  typedef struct packed {
    logic [7:0] sseg;
    logic [2:0] oe;
    logic       done;
  } exp_t;

  digit_t     m_shadow [N];
  digit_t     m_active [N];
  logic [1:0] m_bright;
  int         m_pos;
  exp_t       exp_q [$];

  sseg_scan_array #(
    .SSEG_N(3), .SSEG_BITS(2), .PWM_BITS(2), .PRESCALE(1), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .sel(sel), .val(val), .en(en),
    .sign(sign), .dp(dp), .blink(blink), .brightness(brightness),
    .sseg(sseg), .oe(oe), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] hexFont(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Expected outputs after the edge that consumes frame position m_pos.
  function automatic exp_t predict();
    exp_t   e;
    int     d;
    int     p;
    digit_t a;
    d = m_pos / 4;
    p = m_pos % 4;
    a = m_active[d];
    e.done = (m_pos == FRAME - 1);
    e.oe   = 3'b000;
    e.sseg = 8'hFF;
    if (a.en) begin
      if (a.sign) e.sseg = a.dp ? 8'h3F : 8'hBF;
      else        e.sseg = hexFont(a.val) & (a.dp ? 8'h7F : 8'hFF);
      if (p >= 1 && p <= int'(m_bright)) e.oe = 3'(1 << d);
    end
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_bright = 2'd0;
    m_pos    = 0;
    exp_q.delete();
  endtask

  // One clock: predict and queue, advance the model, then compare #1 after the edge.
  task automatic applyStimulus();
    exp_t e;
    @(posedge clk);
    exp_q.push_back(predict());
    if (m_pos == FRAME - 1) begin
      for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
      m_bright = brightness;
    end
    if (wr && sel < N) m_shadow[sel] = {val, en, sign, dp};
    m_pos = (m_pos + 1) % FRAME;
    #1;
    e = exp_q.pop_front();
    checkOutput("sseg", 32'(sseg), 32'(e.sseg));
    checkOutput("oe", 32'(oe), 32'(e.oe));
    checkOutput("done_tick", 32'(done_tick), 32'(e.done));
    wr = 1'b0;
  endtask

  task automatic writeDigit(input logic [1:0] s, input logic [3:0] v, input logic e_in,
                            input logic sg, input logic d_in);
    wr = 1'b1; sel = s; val = v; en = e_in; sign = sg; dp = d_in;
    applyStimulus();
  endtask

  task automatic runUntil(input int target);
    while (m_pos != target) applyStimulus();
  endtask

  task automatic runFrame(output int lit, output int dones, output logic [7:0] last_seg);
    lit = 0;
    dones = 0;
    last_seg = 8'h00;
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus();
      if (oe != 3'b000) lit++;
      if (done_tick) dones++;
      last_seg = sseg;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sseg"}, 32'(sseg), 32'h0000_00FF);
    checkOutput({tag, "_oe"}, 32'(oe), 32'h0);
    checkOutput({tag, "_done"}, 32'(done_tick), 32'h0);
  endtask

  initial begin
    int         lit;
    int         dones;
    logic [7:0] last_seg;

    reset_n = 1'b0; wr = 1'b0; sel = 2'd0; val = 4'd0; en = 1'b0;
    sign = 1'b0; dp = 1'b0; blink = 1'b0; brightness = 2'd0;
    #12;
    checkResetOutputs("por");
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] mid-scan reset");
    brightness = 2'd3;
    writeDigit(2'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    repeat (2 * FRAME + 5) applyStimulus();
    #3 reset_n = 1'b0;
    #1 checkResetOutputs("midrst");
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] idle frames after reset");
    for (int f = 0; f < 3; f++) begin
      runFrame(lit, dones, last_seg);
      checkOutput("idle_lit", 32'(lit), 32'd0);
      checkOutput("idle_done_count", 32'(dones), 32'd1);
    end

    $display("[TB] single digit write");
    brightness = 2'd3;
    wr = 1'b1; sel = 2'd1; val = 4'd4; en = 1'b1; sign = 1'b0; dp = 1'b0;
    runFrame(lit, dones, last_seg);
    checkOutput("pre_commit_lit", 32'(lit), 32'd0);
    runFrame(lit, dones, last_seg);
    checkOutput("digit1_lit", 32'(lit), 32'd3);

    $display("[TB] dp and sign digits");
    writeDigit(2'd2, 4'd0, 1'b1, 1'b0, 1'b1);
    writeDigit(2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    runUntil(0);
    runFrame(lit, dones, last_seg);
    checkOutput("three_digit_lit", 32'(lit), 32'd9);
    checkOutput("digit2_dp_seg", 32'(last_seg), 32'h40);

    $display("[TB] brightness changes");
    runUntil(5);
    brightness = 2'd1;
    runUntil(0);
    runFrame(lit, dones, last_seg);
    checkOutput("bright1_lit", 32'(lit), 32'd3);
    brightness = 2'd0;
    runFrame(lit, dones, last_seg);
    checkOutput("bright1_hold_lit", 32'(lit), 32'd3);
    runFrame(lit, dones, last_seg);
    checkOutput("bright0_lit", 32'(lit), 32'd0);

    $display("[TB] out-of-range and commit-cycle writes");
    brightness = 2'd3;
    writeDigit(2'd3, 4'd8, 1'b1, 1'b0, 1'b0);
    runUntil(0);
    runFrame(lit, dones, last_seg);
    checkOutput("oor_lit", 32'(lit), 32'd9);
    runUntil(FRAME - 2);
    writeDigit(2'd0, 4'hA, 1'b1, 1'b0, 1'b0);
    writeDigit(2'd2, 4'd5, 1'b1, 1'b0, 1'b0);
    runFrame(lit, dones, last_seg);
    checkOutput("commit_write_old_seg", 32'(last_seg), 32'h40);
    runFrame(lit, dones, last_seg);
    checkOutput("commit_write_new_seg", 32'(last_seg), 32'h92);

    $display("[TB] random traffic");
    for (int i = 0; i < 10 * FRAME; i++) begin
      wr   = 1'($urandom_range(0, 1));
      sel  = 2'($urandom_range(0, 3));
      val  = 4'($urandom_range(0, 15));
      en   = 1'($urandom_range(0, 1));
      sign = 1'($urandom_range(0, 1));
      dp   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) brightness = 2'($urandom_range(0, 3));
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
